// File: rtl/i2c_master_if.sv
// Local-side request/response bundle of the I2C master: transaction setup,
// enable, completion strobe and the byte captured in a read.
interface i2c_master_if;
    logic [7:0] byte_2_send;
    logic [7:0] byte_received;
    logic       ena_i2c;
    logic       end_trans;
    logic       msb_lsb;
    logic [7:0] adrr_r_w;

    modport master (
        input  byte_2_send,
        input  ena_i2c,
        input  msb_lsb,
        input  adrr_r_w,
        output byte_received,
        output end_trans
    );

    modport slave (
        output byte_2_send,
        output ena_i2c,
        output msb_lsb,
        output adrr_r_w,
        input  byte_received,
        input  end_trans
    );
endinterface

// File: rtl/i2c_master.sv
// Single-master I2C controller: one START, address+R/W byte, slave ACK, one
// data byte (write or read), ACK/NACK and STOP per enable.
// SCL is push-pull; SDA is open-drain (driven low or released).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | SCL high, SDA released, waiting for an armed enable
// START    | SDA low while SCL high for 2 quarters, then SCL low
// ADDR     | shifting out the latched address+R/W byte
// ADDR_ACK | SDA released, slave ACK sampled at SCL rise
// WR_DATA  | shifting out the latched data byte
// RD_DATA  | SDA released, 8 data bits sampled at SCL rise
// DATA_ACK | SDA released (slave ACK on write, master NACK on read)
// STOP     | SDA low, SCL rises, then SDA rises while SCL high
module i2c_master #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic         clk,
    input  logic         arstn,
    i2c_master_if.master bus,
    inout  wire          sda,
    output logic         scl
);
    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLOAD = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, RD_DATA, DATA_ACK, STOP
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic          r_armed;
    logic          r_scl;
    logic          r_sda_low;
    logic          r_end_trans;
    logic          r_ack;
    logic          r_msb;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;
    logic [7:0]    r_rx;
    logic [7:0]    r_byte_received;
    logic          w_tick;
    logic          w_sda_in;

    // Wire position n (0 = first on the bus) maps to this byte bit.
    function automatic logic [2:0] bit_pos(input logic msb, input logic [2:0] n);
        return msb ? (3'd7 - n) : n;
    endfunction

    assign w_tick            = (r_qcnt == '0);
    assign w_sda_in          = sda;
    assign sda               = r_sda_low ? 1'b0 : 1'bz;
    assign scl               = r_scl;
    assign bus.end_trans     = r_end_trans;
    assign bus.byte_received = r_byte_received;

    // Quarter-bit sequencer: one step per quarter, all bus outputs registered.
    always_ff @(posedge clk) begin
        if (arstn) begin
            r_state         <= IDLE;
            r_qcnt          <= QLOAD;
            r_q             <= '0;
            r_bit           <= '0;
            r_armed         <= 1'b1;
            r_scl           <= 1'b1;
            r_sda_low       <= 1'b0;
            r_end_trans     <= 1'b0;
            r_ack           <= 1'b1;
            r_msb           <= 1'b1;
            r_addr          <= '0;
            r_data          <= '0;
            r_rx            <= '0;
            r_byte_received <= '0;
        end else begin
            r_end_trans <= 1'b0;
            if (r_state != IDLE) begin
                r_qcnt <= w_tick ? QLOAD : r_qcnt - QW'(1);
            end
            case (r_state)
                IDLE: begin
                    r_scl     <= 1'b1;
                    r_sda_low <= 1'b0;
                    if (!bus.ena_i2c) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed   <= 1'b0;
                        r_addr    <= bus.adrr_r_w;
                        r_data    <= bus.byte_2_send;
                        r_msb     <= bus.msb_lsb;
                        r_sda_low <= 1'b1;
                        r_q       <= '0;
                        r_qcnt    <= QLOAD;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        if (r_q == 2'd1) begin
                            r_scl     <= 1'b0;
                            r_sda_low <= ~r_addr[bit_pos(r_msb, 3'd0)];
                            r_bit     <= '0;
                            r_q       <= '0;
                            r_state   <= ADDR;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        if (r_q == 2'd0) begin
                            r_scl <= 1'b1;
                        end else begin
                            r_sda_low <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                ADDR, ADDR_ACK, WR_DATA, RD_DATA, DATA_ACK: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        if (r_q == 2'd1) begin
                            // SCL rising edge: the only point where SDA is read
                            r_scl <= 1'b1;
                            if (r_state == RD_DATA) begin
                                r_rx[bit_pos(r_msb, r_bit)] <= w_sda_in;
                            end
                            if (r_state == ADDR_ACK || r_state == DATA_ACK) begin
                                r_ack <= w_sda_in;
                            end
                        end else if (r_q == 2'd3) begin
                            // SCL falling edge: set up SDA for the next bit
                            r_scl <= 1'b0;
                            case (r_state)
                                ADDR: begin
                                    if (r_bit == 3'd7) begin
                                        r_sda_low <= 1'b0;
                                        r_state   <= ADDR_ACK;
                                    end else begin
                                        r_bit     <= r_bit + 3'd1;
                                        r_sda_low <= ~r_addr[bit_pos(r_msb, r_bit + 3'd1)];
                                    end
                                end
                                ADDR_ACK: begin
                                    r_end_trans <= 1'b1;
                                    r_bit       <= '0;
                                    if (r_ack) begin
                                        r_sda_low <= 1'b1;
                                        r_state   <= STOP;
                                    end else if (r_addr[0]) begin
                                        r_sda_low <= 1'b0;
                                        r_state   <= RD_DATA;
                                    end else begin
                                        r_sda_low <= ~r_data[bit_pos(r_msb, 3'd0)];
                                        r_state   <= WR_DATA;
                                    end
                                end
                                WR_DATA: begin
                                    if (r_bit == 3'd7) begin
                                        r_sda_low <= 1'b0;
                                        r_state   <= DATA_ACK;
                                    end else begin
                                        r_bit     <= r_bit + 3'd1;
                                        r_sda_low <= ~r_data[bit_pos(r_msb, r_bit + 3'd1)];
                                    end
                                end
                                RD_DATA: begin
                                    r_sda_low <= 1'b0;
                                    if (r_bit == 3'd7) begin
                                        r_state <= DATA_ACK;
                                    end else begin
                                        r_bit <= r_bit + 3'd1;
                                    end
                                end
                                default: begin
                                    // DATA_ACK: the sampled ACK is informational only
                                    r_end_trans <= 1'b1;
                                    if (r_addr[0]) begin
                                        r_byte_received <= r_rx;
                                    end
                                    r_sda_low <= 1'b1;
                                    r_state   <= STOP;
                                end
                            endcase
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a behavioural I2C slave/monitor decodes
// the bus into START/STOP events and bit lists; transactions are checked
// against expectations computed from the transaction parameters.
module tb_i2c_master;
    localparam int CLK_FREQ = 4_000_000;
    localparam int I2C_FREQ = 100_000;
    localparam int QDIV     = CLK_FREQ / (4 * I2C_FREQ);

    logic clk   = 1'b0;
    logic arstn = 1'b1;
    wire  sda_w;
    logic scl_w;
    logic slv_low = 1'b0;

    i2c_master_if bus ();

    i2c_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus),
        .sda   (sda_w),
        .scl   (scl_w)
    );

    pullup (sda_w);
    assign sda_w = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave configuration for the current transaction
    logic       slv_ack_addr = 1'b1;
    logic       slv_ack_data = 1'b1;
    logic       slv_msb      = 1'b1;
    logic [7:0] slv_rd_byte  = 8'h00;
    logic [7:0] mdl_rcv      = 8'h00;

    // bus monitor state
    int         mon_starts = 0;
    int         mon_stops  = 0;
    logic       mon_bits[$];
    int         mon_hi[$];
    int         mon_lo[$];
    int         mon_pulse_rise[$];
    int         mon_pulse_fall_ok[$];
    logic [7:0] mon_pulse_rcv[$];
    int         run_len = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    // Behavioural slave + monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        logic sda_now;
        int   n;
        int   k;
        logic is_rd;
        sda_now = (sda_w !== 1'b0);
        if (bus.end_trans === 1'b1) begin
            mon_pulse_rise.push_back(mon_bits.size());
            mon_pulse_fall_ok.push_back((prev_scl && !scl_w) ? 1 : 0);
            mon_pulse_rcv.push_back(bus.byte_received);
        end
        if (prev_scl && scl_w && prev_sda && !sda_now) begin
            mon_starts++;
            mon_bits.delete();
            mon_hi.delete();
            mon_lo.delete();
            mon_pulse_rise.delete();
            mon_pulse_fall_ok.delete();
            mon_pulse_rcv.delete();
            slv_low = 1'b0;
        end
        if (prev_scl && scl_w && !prev_sda && sda_now) mon_stops++;
        if (!prev_scl && scl_w) begin
            mon_bits.push_back(sda_now);
            mon_lo.push_back(run_len);
            run_len = 1;
        end else if (prev_scl && !scl_w) begin
            mon_hi.push_back(run_len);
            run_len = 1;
            n = mon_bits.size();
            is_rd = (n >= 8) ? mon_bits[slv_msb ? 7 : 0] : 1'b0;
            slv_low = 1'b0;
            if (n == 8) begin
                slv_low = slv_ack_addr;
            end else if (slv_ack_addr && is_rd && n >= 9 && n <= 16) begin
                k = slv_msb ? (16 - n) : (n - 9);
                slv_low = !slv_rd_byte[k];
            end else if (slv_ack_addr && !is_rd && n == 17) begin
                slv_low = slv_ack_data;
            end
        end else begin
            run_len++;
        end
        prev_scl = scl_w;
        prev_sda = sda_now;
    end

    // Reassemble 8 monitored wire bits starting at base into a byte.
    function automatic logic [7:0] assemble(input int base, input logic msb);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[msb ? 7 - i : i] = mon_bits[base + i];
        return v;
    endfunction

    task automatic run_txn(input string tag, input logic [7:0] addr, input logic [7:0] data,
                           input logic msb, input logic ack_a, input logic ack_d,
                           input logic [7:0] rd_byte, input int hold);
        int   s0, p0, nexp, bad;
        logic started, done;
        s0 = mon_starts;
        p0 = mon_stops;
        slv_ack_addr = ack_a;
        slv_ack_data = ack_d;
        slv_msb      = msb;
        slv_rd_byte  = rd_byte;
        @(posedge clk); #1;
        bus.adrr_r_w    = addr;
        bus.byte_2_send = data;
        bus.msb_lsb     = msb;
        bus.ena_i2c     = 1'b1;
        started = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 30 * 4 * QDIV && !done; c++) begin
            @(posedge clk); #1;
            if (!started && mon_starts != s0) begin
                started = 1'b1;
                bus.adrr_r_w    = ~addr;
                bus.byte_2_send = ~data;
                bus.msb_lsb     = ~msb;
            end
            if (mon_stops != p0) done = 1'b1;
        end
        check_eq({tag, " completed"}, done, 1);
        repeat (hold) @(posedge clk);
        #1 bus.ena_i2c = 1'b0;
        repeat (4 * QDIV) @(posedge clk);
        #1;
        nexp = ack_a ? 18 : 9;
        if (ack_a && addr[0]) mdl_rcv = rd_byte;
        check_eq({tag, " starts"}, mon_starts - s0, 1);
        check_eq({tag, " stops"}, mon_stops - p0, 1);
        check_eq({tag, " addr"}, assemble(0, msb), addr);
        check_eq({tag, " nbits"}, mon_bits.size(), nexp + 1);
        check_eq({tag, " npulses"}, mon_pulse_rise.size(), ack_a ? 2 : 1);
        check_eq({tag, " pulse1 pos"}, mon_pulse_rise.size() > 0 ? mon_pulse_rise[0] : -1, 9);
        check_eq({tag, " pulse1 edge"}, mon_pulse_fall_ok.size() > 0 ? mon_pulse_fall_ok[0] : 0, 1);
        if (ack_a) begin
            check_eq({tag, " pulse2 pos"}, mon_pulse_rise.size() > 1 ? mon_pulse_rise[1] : -1, 18);
            check_eq({tag, " pulse2 edge"}, mon_pulse_fall_ok.size() > 1 ? mon_pulse_fall_ok[1] : 0, 1);
            if (addr[0]) begin
                check_eq({tag, " master nack"}, mon_bits.size() > 17 ? mon_bits[17] : 1'b0, 1);
                check_eq({tag, " rcv at pulse"},
                         mon_pulse_rcv.size() > 1 ? mon_pulse_rcv[1] : 8'hxx, rd_byte);
            end else begin
                check_eq({tag, " data"}, assemble(9, msb), data);
            end
        end
        check_eq({tag, " byte_received"}, bus.byte_received, mdl_rcv);
        bad = 0;
        for (int i = 1; i <= nexp; i++) if (i >= mon_hi.size() || mon_hi[i] != 2 * QDIV) bad++;
        for (int i = 0; i < nexp; i++) if (i >= mon_lo.size() || mon_lo[i] != 2 * QDIV) bad++;
        if (nexp >= mon_lo.size() || mon_lo[nexp] != QDIV) bad++;
        check_eq({tag, " scl timing"}, bad, 0);
    endtask

    initial begin
        int   s0;
        logic hit;
        logic [7:0] a, d, r;
        bus.adrr_r_w    = 8'h00;
        bus.byte_2_send = 8'h00;
        bus.msb_lsb     = 1'b1;
        bus.ena_i2c     = 1'b0;
        arstn           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset scl", scl_w, 1);
        check_eq("reset sda", sda_w, 1);
        check_eq("reset end_trans", bus.end_trans, 0);
        check_eq("reset byte_received", bus.byte_received, 8'h00);
        arstn = 1'b0;
        repeat (2) @(posedge clk);

        run_txn("wr A0/55", 8'hA0, 8'h55, 1'b1, 1'b1, 1'b1, 8'h00, 0);
        run_txn("rd A1/FE", 8'hA1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFE, 0);
        run_txn("lsb wr A0", 8'hA0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00, 0);
        s0 = 0;
        for (int i = 0; i < 8; i++) s0 = (s0 << 1) | int'(mon_bits[i]);
        check_eq("lsb wire order", s0, 32'b0000_0101);
        run_txn("hold ena", 8'h42, 8'h81, 1'b1, 1'b1, 1'b0, 8'h00, 16 * 4 * QDIV);
        run_txn("rearmed rd", 8'h43, 8'h00, 1'b0, 1'b1, 1'b1, 8'h6B, 0);
        run_txn("addr nack", 8'hA4, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, 0);

        // reset in the middle of the address phase
        s0 = mon_starts;
        slv_ack_addr = 1'b1;
        slv_msb      = 1'b1;
        @(posedge clk); #1;
        bus.adrr_r_w    = 8'h00;
        bus.byte_2_send = 8'h00;
        bus.msb_lsb     = 1'b1;
        bus.ena_i2c     = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 * 4 * QDIV && !hit; c++) begin
            @(posedge clk); #1;
            if (mon_starts != s0 && mon_bits.size() >= 3 && scl_w == 1'b0) hit = 1'b1;
        end
        check_eq("midrst reached addr", hit, 1);
        arstn       = 1'b1;
        bus.ena_i2c = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst scl", scl_w, 1);
        check_eq("midrst sda", sda_w, 1);
        check_eq("midrst end_trans", bus.end_trans, 0);
        check_eq("midrst byte_received", bus.byte_received, 8'h00);
        mdl_rcv = 8'h00;
        arstn   = 1'b0;
        s0 = mon_starts;
        repeat (12 * QDIV) @(posedge clk);
        #1 check_eq("midrst idle", mon_starts - s0, 0);

        for (int t = 0; t < 8; t++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            run_txn($sformatf("rand%0d", t), a, d, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), r, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
